int_div_dispatch: RTL
=====================

# int_div_dispatch

Sequencing stage around the multi-cycle unsigned integer divider. It accepts signed and unsigned divide/remainder requests from the core's execute stage and converts signed operands to magnitudes. It drives the divider's req/ack handshake, then sign-corrects the result and presents it with its destination register index for register-file writeback. Division by zero and signed overflow are resolved locally without invoking the divider.

## Interface
- data_width, 32, operand/result width (power of two)
- num_regs, 32, register file depth
- reg_sel_width, $clog2(num_regs), destination register index width
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- req_valid  input  1  core presents a request
- req_ready  output  1  block can accept; high only in IDLE
- req_op  input  2  00 DIVU, 01 DIV, 10 REMU, 11 REM
- req_rd  input  reg_sel_width  destination register
- req_a  input  data_width  dividend
- req_b  input  data_width  divisor
- div_req  output  1  one-cycle start pulse to divider
- div_a  output  data_width  unsigned dividend to divider
- div_b  output  data_width  unsigned divisor to divider
- div_ack  input  1  divider done pulse; quotient/remainder valid same cycle
- div_quotient  input  data_width  divider quotient
- div_remainder  input  data_width  divider remainder
- wb_valid  output  1  result available
- wb_ready  input  1  writeback accepts result
- wb_rd  output  reg_sel_width  destination register of result
- wb_data  output  data_width  result
- busy  output  1  high in every state except IDLE

## Operation
- States: IDLE, ISSUE, WAIT, WB.
- IDLE: accept when req_valid && req_ready. Register op, rd, operand signs, magnitudes. Next state ISSUE, or WB directly for special cases.
- Signed ops (DIV/REM): magnitude = two's-complement negate if MSB set; most-negative value passes unchanged as unsigned 2^(data_width-1). Unsigned ops pass operands unchanged.
- Special cases, result computed at accept, bypass divider:
  - b == 0: DIV/DIVU -> all ones; REM/REMU -> a.
  - DIV/REM with a == most negative, b == all ones: DIV -> a; REM -> 0.
- ISSUE: div_req = 1 for exactly one cycle; div_a/div_b hold magnitudes; next WAIT.
- WAIT: hold div_a/div_b stable. On div_ack, latch result and go to WB. No cycle limit.
  - DIV: quotient, negated if operand signs differ.
  - REM: remainder, negated if dividend negative.
  - Unsigned ops: raw value.
- WB: wb_valid = 1, wb_rd/wb_data stable until wb_valid && wb_ready, then IDLE.
- div_ack outside WAIT is ignored, including stale acks after reset.
- Reset, asynchronous, any state:
  - State -> IDLE; req_ready = 1.
  - div_req, wb_valid, busy = 0.
  - div_a, div_b, wb_rd, wb_data = 0.
  - In-flight operation discarded.

## Timing
- Accept at edge T; ISSUE during T+1, div_req high T+1 only. The divider samples operands at the end of T+1.
- Normal path: wb_valid rises the cycle after div_ack. Total latency = 2 + divider latency (data_width + 1 cycles for the current divider) to wb_valid.
- Special-case path: wb_valid high in cycle T+1.
- wb_ready may be high before wb_valid; handshake completes in the first cycle both are high. Earliest next accept is the following cycle, so there is one request in flight max.
- Operands on req_* are don't-care except in the accept cycle.

## Test plan
- DIVU 100 / 7, rd=5 -> div_req one pulse with div_a=100, div_b=7; after ack, wb_valid with wb_rd=5, wb_data=14.
- DIV -100 / 7 and REM -100 / 7 -> wb_data = -14 (0xFFFFFFF2) and -2 (0xFFFFFFFE). REM 100 / -7 -> 2.
- DIVU 55 / 0 -> no div_req; wb_valid at T+1, wb_data=0xFFFFFFFF. REMU 55 / 0 -> 55.
- DIV 0x80000000 / 0xFFFFFFFF -> no div_req; wb_data=0x80000000. REM same operands -> 0.
- Hold wb_ready low 5 cycles -> wb_valid/wb_data stable, req_ready low, req_valid ignored. Release -> IDLE next cycle, new request accepted.
- Assert rst_n low during WAIT, release, then drive a spurious div_ack -> all outputs at reset values, ack ignored, next DIVU 9 / 3 returns 3.

Source files
------------

// File: rtl/int_div_dispatch.sv
// Issues divide/remainder requests to the multi-cycle unsigned divider: it takes
// operand magnitudes, sign-corrects the result, and resolves divide-by-zero/overflow locally.
module int_div_dispatch #(
  parameter int DATA_WIDTH    = 32,
  parameter int NUM_REGS      = 32,
  parameter int REG_SEL_WIDTH = $clog2(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [1:0]               req_op,
  input  logic [REG_SEL_WIDTH-1:0] req_rd,
  input  logic [DATA_WIDTH-1:0]    req_a,
  input  logic [DATA_WIDTH-1:0]    req_b,
  output logic                     div_req,
  output logic [DATA_WIDTH-1:0]    div_a,
  output logic [DATA_WIDTH-1:0]    div_b,
  input  logic                     div_ack,
  input  logic [DATA_WIDTH-1:0]    div_quotient,
  input  logic [DATA_WIDTH-1:0]    div_remainder,
  output logic                     wb_valid,
  input  logic                     wb_ready,
  output logic [REG_SEL_WIDTH-1:0] wb_rd,
  output logic [DATA_WIDTH-1:0]    wb_data,
  output logic                     busy
);
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_WB} state_t;

  localparam logic [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [DATA_WIDTH-1:0] ONE      = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

  state_t r_state, w_state_nxt;

  logic                     r_is_rem, r_a_neg, r_b_neg;
  logic [REG_SEL_WIDTH-1:0] r_rd;
  logic [DATA_WIDTH-1:0]    r_div_a, r_div_b, r_wb_data;

  logic                     w_accept, w_signed, w_rem, w_a_neg, w_b_neg;
  logic                     w_div_zero, w_ovf, w_special, w_neg_res;
  logic [DATA_WIDTH-1:0]    w_a_mag, w_b_mag, w_special_res, w_raw, w_res;

  // op[0] selects signed, op[1] selects remainder
  assign w_accept  = req_valid && (r_state == S_IDLE);
  assign w_signed  = req_op[0];
  assign w_rem     = req_op[1];
  assign w_a_neg   = w_signed & req_a[DATA_WIDTH-1];
  assign w_b_neg   = w_signed & req_b[DATA_WIDTH-1];
  assign w_a_mag   = w_a_neg ? (~req_a + ONE) : req_a;
  assign w_b_mag   = w_b_neg ? (~req_b + ONE) : req_b;

  assign w_div_zero    = (req_b == '0);
  assign w_ovf         = w_signed && (req_a == MOST_NEG) && (req_b == '1);
  assign w_special     = w_div_zero || w_ovf;
  assign w_special_res = w_div_zero ? (w_rem ? req_a : '1) : (w_rem ? '0 : req_a);

  // Remainder takes the dividend's sign; quotient is negative when signs differ.
  assign w_raw     = r_is_rem ? div_remainder : div_quotient;
  assign w_neg_res = r_is_rem ? r_a_neg : (r_a_neg ^ r_b_neg);
  assign w_res     = w_neg_res ? (~w_raw + ONE) : w_raw;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = w_special ? S_WB : S_ISSUE;
      S_ISSUE: w_state_nxt = S_WAIT;
      S_WAIT:  if (div_ack) w_state_nxt = S_WB;
      S_WB:    if (wb_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_is_rem  <= 1'b0;
      r_a_neg   <= 1'b0;
      r_b_neg   <= 1'b0;
      r_rd      <= '0;
      r_div_a   <= '0;
      r_div_b   <= '0;
      r_wb_data <= '0;
    end else begin
      if (w_accept) begin
        r_is_rem <= w_rem;
        r_a_neg  <= w_a_neg;
        r_b_neg  <= w_b_neg;
        r_rd     <= req_rd;
        r_div_a  <= w_a_mag;
        r_div_b  <= w_b_mag;
        if (w_special) r_wb_data <= w_special_res;
      end
      if ((r_state == S_WAIT) && div_ack) r_wb_data <= w_res;
    end
  end

  assign req_ready = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign div_req   = (r_state == S_ISSUE);
  assign wb_valid  = (r_state == S_WB);
  assign div_a     = r_div_a;
  assign div_b     = r_div_b;
  assign wb_rd     = r_rd;
  assign wb_data   = r_wb_data;
endmodule
